branch_redirect_unit: RTL and testbench
=======================================

// Module: branch_redirect_unit
// PURPOSE
// - Consumes the EX-stage taken/not-taken decision (switch_branch) and turns it into a PC redirect plus pipeline flush.
// - Computes and latches the branch target, drives the PC-source select for one cycle, and squashes wrong-path IF/ID and ID/EX slots.
// - Sits between EX-stage branch resolution and the IF-stage PC mux / hazard unit.
// - Keeps a saturating count of taken branches for performance debug.
// PARAMETERS
// - XLEN         64  datapath/address width
// - FLUSH_CYCLES 2   total cycles flush_ifid is held after a taken branch (legal range 1..7)
// - CNT_W        32  width of taken-branch counter
// PORTS
// - clk             in   1     rising-edge clock
// - reset           in   1     asynchronous, active-low reset
// - stall           in   1     pipeline hold from hazard unit; freezes this block
// - ex_valid        in   1     EX stage holds a real, non-bubble instruction
// - switch_branch   in   1     branch taken, from EX branch control
// - ex_pc           in   XLEN  PC of the instruction in EX
// - ex_imm          in   XLEN  sign-extended B-type immediate, unshifted
// - pc_sel          out  1     1 = IF selects pc_target instead of PC+4
// - pc_target       out  XLEN  latched redirect address
// - flush_ifid      out  1     zero the IF/ID register this cycle
// - flush_idex      out  1     zero the ID/EX register this cycle
// - redirect_busy   out  1     high in any state other than IDLE
// - taken_count     out  CNT_W saturating count of accepted taken branches
// BEHAVIOUR
// - Reset (reset==0, async): state=IDLE, pc_target=0, taken_count=0, cnt=0; all 1-bit outputs 0.
// - All outputs are registered; none is combinational from the inputs.
// - Target arithmetic: pc_target = ex_pc + (ex_imm << 1), computed mod 2^XLEN (wrap-around, no overflow flag).
// - Accept condition: state==IDLE && ex_valid && switch_branch && !stall.
// - FSM states:
//   - IDLE:
//     - On accept: latch pc_target, taken_count += 1 (held at all-ones once saturated), go to REDIRECT.
//     - Otherwise stay in IDLE.
//   - REDIRECT (exactly 1 unstalled cycle):
//     - pc_sel=1, flush_ifid=1, flush_idex=1.
//     - Next state: FLUSH with cnt = FLUSH_CYCLES-1 if FLUSH_CYCLES > 1; else IDLE.
//   - FLUSH:
//     - pc_sel=0, flush_idex=0, flush_ifid=1; cnt decrements each unstalled cycle.
//     - Go to IDLE when cnt reaches 0 after decrement.
// - Latency: accept at edge N, so pc_sel/flushes are high during cycle N+1.
// - With FLUSH_CYCLES=2, flush_ifid is high in cycles N+1 and N+2.
// - stall=1 freezes state, cnt, and every output at its current value.
//   - An in-progress redirect/flush is therefore held, not dropped.
//   - No new accept occurs while stalled.
// - While redirect_busy=1, switch_branch/ex_valid are ignored: those instructions are wrong-path and are being flushed.
// - Back-to-back: a branch presented on the first IDLE cycle after FLUSH completes is accepted normally (no dead cycle).
// - ex_valid=0 with switch_branch=1: no accept; a bubble never redirects.
// - Reset asserted mid-REDIRECT/FLUSH: immediate return to reset values.
//   - Deasserting reset while redirect_busy=1 does not resume the old redirect.
// - X on switch_branch while ex_valid=0 must not propagate to outputs.
// TESTING
// - T1 taken branch: ex_pc=0x1000, ex_imm=0x10, taken -> next cycle pc_sel=1, pc_target=0x1020, both flushes=1.
//   - Following cycle: flush_ifid=1 only. Then IDLE; taken_count=1.
// - T2 not taken / bubble: switch_branch=0, or ex_valid=0 with switch_branch=1 -> outputs stay 0, taken_count unchanged.
// - T3 stall hold: accept, then stall=1 for 3 cycles during REDIRECT -> pc_sel=1 held 4 cycles total.
//   - Flush sequence then completes normally.
// - T4 wrap-around: ex_pc=0xFFFF_FFFF_FFFF_FFF8, ex_imm=0x8 -> pc_target=0x8.
//   - Negative case: ex_pc=0x1000, ex_imm=-8 -> pc_target=0x0FF0.
// - T5 ignore in flight: switch_branch=1 every cycle from accept -> exactly one redirect per IDLE->REDIRECT->FLUSH->IDLE pass.
//   - taken_count increments once per pass.
// - T6 async reset mid-FLUSH (reset low between clock edges) -> all outputs 0 immediately, without waiting for clk.
//   - taken_count=0; IDLE after release.

Source files
------------

// File: rtl/branch_redirect_unit.sv
// ============================================================================
// branch_redirect_unit: turns an EX-stage taken branch into a one-cycle PC
// redirect plus IF/ID and ID/EX flushes; counts taken branches.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_redirect_unit #(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             switch_branch,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  output logic             pc_sel,
  output logic [XLEN-1:0]  pc_target,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             redirect_busy,
  output logic [CNT_W-1:0] taken_count
);

  localparam int         C_CNT_BITS   = 3;
  localparam logic [1:0] C_S_IDLE     = 2'd0;
  localparam logic [1:0] C_S_REDIRECT = 2'd1;
  localparam logic [1:0] C_S_FLUSH    = 2'd2;

  localparam logic [C_CNT_BITS-1:0] C_FLUSH_LOAD = C_CNT_BITS'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0]      C_CNT_MAX    = '1;

  logic [1:0]            r_state;
  logic [C_CNT_BITS-1:0] r_cnt;
  logic                  w_accept;
  logic [XLEN-1:0]       w_target;

  // A bubble (ex_valid=0) gates switch_branch so an X there cannot leak through.
  assign w_accept = (r_state == C_S_IDLE) && ex_valid && switch_branch && !stall;
  assign w_target = ex_pc + (ex_imm << 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= C_S_IDLE;
      r_cnt         <= '0;
      pc_sel        <= 1'b0;
      pc_target     <= '0;
      flush_ifid    <= 1'b0;
      flush_idex    <= 1'b0;
      redirect_busy <= 1'b0;
      taken_count   <= '0;
    end else if (!stall) begin
      case (r_state)
        C_S_IDLE: begin
          if (w_accept) begin
            r_state       <= C_S_REDIRECT;
            pc_target     <= w_target;
            pc_sel        <= 1'b1;
            flush_ifid    <= 1'b1;
            flush_idex    <= 1'b1;
            redirect_busy <= 1'b1;
            if (taken_count != C_CNT_MAX) begin
              taken_count <= taken_count + 1'b1;
            end
          end else begin
            pc_sel        <= 1'b0;
            flush_ifid    <= 1'b0;
            flush_idex    <= 1'b0;
            redirect_busy <= 1'b0;
          end
        end

        C_S_REDIRECT: begin
          pc_sel     <= 1'b0;
          flush_idex <= 1'b0;
          if (FLUSH_CYCLES > 1) begin
            r_state       <= C_S_FLUSH;
            r_cnt         <= C_FLUSH_LOAD;
            flush_ifid    <= 1'b1;
            redirect_busy <= 1'b1;
          end else begin
            r_state       <= C_S_IDLE;
            flush_ifid    <= 1'b0;
            redirect_busy <= 1'b0;
          end
        end

        C_S_FLUSH: begin
          r_cnt <= r_cnt - 1'b1;
          // Outputs are registered, so leave FLUSH on the cycle the count hits zero.
          if (r_cnt <= C_CNT_BITS'(1)) begin
            r_state       <= C_S_IDLE;
            flush_ifid    <= 1'b0;
            redirect_busy <= 1'b0;
          end else begin
            flush_ifid    <= 1'b1;
            redirect_busy <= 1'b1;
          end
        end

        default: begin
          r_state       <= C_S_IDLE;
          r_cnt         <= '0;
          pc_sel        <= 1'b0;
          flush_ifid    <= 1'b0;
          flush_idex    <= 1'b0;
          redirect_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_redirect_unit.sv
// ============================================================================
// tb_branch_redirect_unit: directed self-checking bench for branch_redirect_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_branch_redirect_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        ex_valid;
  logic        switch_branch;
  logic [63:0] ex_pc;
  logic [63:0] ex_imm;
  logic        pc_sel;
  logic [63:0] pc_target;
  logic        flush_ifid;
  logic        flush_idex;
  logic        redirect_busy;
  logic [31:0] taken_count;

  int checks = 0;
  int errors = 0;

  branch_redirect_unit #(.XLEN(64), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .ex_valid      (ex_valid),
    .switch_branch (switch_branch),
    .ex_pc         (ex_pc),
    .ex_imm        (ex_imm),
    .pc_sel        (pc_sel),
    .pc_target     (pc_target),
    .flush_ifid    (flush_ifid),
    .flush_idex    (flush_idex),
    .redirect_busy (redirect_busy),
    .taken_count   (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks the 1-bit outputs plus busy in one call.
  task automatic chk_flags(input string tag, input logic ps, input logic fi,
                           input logic fx, input logic bz);
    chk({tag, ".pc_sel"}, {63'd0, pc_sel}, {63'd0, ps});
    chk({tag, ".flush_ifid"}, {63'd0, flush_ifid}, {63'd0, fi});
    chk({tag, ".flush_idex"}, {63'd0, flush_idex}, {63'd0, fx});
    chk({tag, ".busy"}, {63'd0, redirect_busy}, {63'd0, bz});
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; ex_valid = 1'b0; switch_branch = 1'b0;
    ex_pc = '0; ex_imm = '0;
    tick(); tick();
    chk_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.target", pc_target, 64'h0);
    chk("reset.count", {32'd0, taken_count}, 64'd0);
    reset = 1'b1;
    tick();

    // T1 taken branch
    ex_valid = 1'b1; switch_branch = 1'b1; ex_pc = 64'h1000; ex_imm = 64'h10;
    tick();
    ex_valid = 1'b0; switch_branch = 1'b0;
    chk_flags("t1.redirect", 1'b1, 1'b1, 1'b1, 1'b1);
    chk("t1.target", pc_target, 64'h1020);
    chk("t1.count", {32'd0, taken_count}, 64'd1);
    tick();
    chk_flags("t1.flush", 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk_flags("t1.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1.count_after", {32'd0, taken_count}, 64'd1);

    // T2 not taken, bubble, X on switch_branch under a bubble
    ex_valid = 1'b1; switch_branch = 1'b0;
    tick();
    chk_flags("t2.not_taken", 1'b0, 1'b0, 1'b0, 1'b0);
    ex_valid = 1'b0; switch_branch = 1'b1;
    tick();
    chk_flags("t2.bubble", 1'b0, 1'b0, 1'b0, 1'b0);
    switch_branch = 1'bx;
    tick();
    chk_flags("t2.x_bubble", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2.count", {32'd0, taken_count}, 64'd1);
    switch_branch = 1'b0;

    // T3 stall hold during REDIRECT
    ex_valid = 1'b1; switch_branch = 1'b1; ex_pc = 64'h2000; ex_imm = 64'h4;
    tick();
    ex_valid = 1'b0; switch_branch = 1'b0; stall = 1'b1;
    chk_flags("t3.redirect", 1'b1, 1'b1, 1'b1, 1'b1);
    chk("t3.target", pc_target, 64'h2008);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_flags("t3.stalled", 1'b1, 1'b1, 1'b1, 1'b1);
    end
    stall = 1'b0;
    tick();
    chk_flags("t3.flush", 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk_flags("t3.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3.count", {32'd0, taken_count}, 64'd2);

    // T4 wrap-around and negative offset
    ex_valid = 1'b1; switch_branch = 1'b1;
    ex_pc = 64'hFFFF_FFFF_FFFF_FFF8; ex_imm = 64'h8;
    tick();
    ex_valid = 1'b0; switch_branch = 1'b0;
    chk("t4.wrap_target", pc_target, 64'h8);
    chk("t4.count", {32'd0, taken_count}, 64'd3);
    tick(); tick();
    ex_valid = 1'b1; switch_branch = 1'b1;
    ex_pc = 64'h1000; ex_imm = -64'sd8;
    tick();
    ex_valid = 1'b0; switch_branch = 1'b0;
    chk("t4.neg_target", pc_target, 64'h0FF0);
    chk("t4.neg_count", {32'd0, taken_count}, 64'd4);
    tick(); tick();
    chk_flags("t4.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // T5 switch_branch held high: one redirect per pass
    ex_valid = 1'b1; switch_branch = 1'b1; ex_pc = 64'h3000; ex_imm = 64'h0;
    tick();
    chk_flags("t5.redirect1", 1'b1, 1'b1, 1'b1, 1'b1);
    chk("t5.count1", {32'd0, taken_count}, 64'd5);
    tick();
    chk_flags("t5.flush1", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t5.count_flush", {32'd0, taken_count}, 64'd5);
    tick();
    chk_flags("t5.idle1", 1'b0, 1'b0, 1'b0, 1'b0);
    ex_pc = 64'h3100;
    tick();
    chk_flags("t5.redirect2", 1'b1, 1'b1, 1'b1, 1'b1);
    chk("t5.target2", pc_target, 64'h3100);
    chk("t5.count2", {32'd0, taken_count}, 64'd6);
    ex_valid = 1'b0; switch_branch = 1'b0;
    tick(); tick();
    chk_flags("t5.idle2", 1'b0, 1'b0, 1'b0, 1'b0);

    // T6 async reset mid-FLUSH
    ex_valid = 1'b1; switch_branch = 1'b1; ex_pc = 64'h4000; ex_imm = 64'h0;
    tick();
    ex_valid = 1'b0; switch_branch = 1'b0;
    chk("t6.count_pre", {32'd0, taken_count}, 64'd7);
    tick();
    chk_flags("t6.flush", 1'b0, 1'b1, 1'b0, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk_flags("t6.async", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6.target", pc_target, 64'h0);
    chk("t6.count", {32'd0, taken_count}, 64'd0);
    tick();
    reset = 1'b1;
    tick();
    chk_flags("t6.released", 1'b0, 1'b0, 1'b0, 1'b0);
    ex_valid = 1'b1; switch_branch = 1'b1; ex_pc = 64'h5000; ex_imm = 64'h2;
    tick();
    ex_valid = 1'b0; switch_branch = 1'b0;
    chk_flags("t6.new_redirect", 1'b1, 1'b1, 1'b1, 1'b1);
    chk("t6.new_target", pc_target, 64'h5004);
    chk("t6.new_count", {32'd0, taken_count}, 64'd1);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
